pipelined_ctrl_decoder: RTL and testbench
=========================================

Name: pipelined_ctrl_decoder

Overview:
Registered instruction-decode control stage for the RV32I(+M) core, placed between the fetch/IF-ID register and execute. It decodes opcode, funct3 and funct7 into the control bundle and holds it in an ID/EX output register under a valid/ready handshake. It also detects load-use hazards and inserts a bubble, supports a flush, and keeps saturating stall and bubble counters.

Parameters:
ENABLE_M, 1, 1 = decode the M-extension (funct7 0000001 on OP) as md_op; 0 = flag it illegal
LOAD_USE_INTERLOCK, 1, 1 = enable load-use hazard bubble insertion; 0 = never stall
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  instr is valid
in_ready  out  1  stage accepts instr this cycle
instr  in  32  instruction word
flush  in  1  kill the stage contents (branch/jump redirect)
out_valid  out  1  output bundle valid
out_ready  in  1  execute accepts the bundle
reg_wen, alu_src, mem_rw, mem_to_reg, branch, br_un, jump  out  1 each  registered controls
alu_op  out  2  00 R, 10 I-arith, 01 addr/pass, 11 branch
md_op  out  1  M-extension operation
illegal  out  1  unsupported encoding
rd, rs1, rs2  out  5 each  registered register indices
stall_cnt  out  CNT_W  cycles with hazard stall
bubble_cnt  out  CNT_W  bubbles inserted, including flush kills

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): out_valid=0; all control outputs, rd, rs1, rs2 and alu_op=0; stall_cnt and bubble_cnt=0. in_ready is combinational and equals 1 after reset.
- Decode table (combinational, then registered). Every output not listed is 0.
  - OP 0110011: reg_wen, alu_op=00. If funct7=0000001: md_op=1 when ENABLE_M=1, otherwise illegal=1 with all other controls 0.
  - OP-IMM 0010011: reg_wen, alu_src, alu_op=10.
  - LOAD 0000011: reg_wen, alu_src, mem_to_reg, alu_op=01.
  - STORE 0100011: alu_src, mem_rw, alu_op=01.
  - BRANCH 1100011: branch, alu_op=11; br_un=1 iff funct3 is 110 or 111.
  - LUI 0110111 and AUIPC 0010111: reg_wen, alu_src, alu_op=01.
  - JAL 1101111 and JALR 1100111: reg_wen, alu_src, jump, alu_op=01.
  - Any other opcode: illegal=1, alu_op=00. No x values are ever driven.
- Source usage:
  - uses_rs1 is set for OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - uses_rs2 is set for OP, STORE, BRANCH.
- Hazard (LOAD_USE_INTERLOCK=1): hazard = in_valid & out_valid & mem_to_reg & (rd≠0) & ((uses_rs1 & rs1_in==rd) | (uses_rs2 & rs2_in==rd)), where mem_to_reg and rd are the registered outputs.
- Handshake:
  - adv = !out_valid | out_ready.
  - in_ready = adv & !hazard & !rst.
  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
- Output register update, in priority order per clk edge:
  1. rst: reset values.
  2. flush: out_valid←0. Any instr accepted this cycle is discarded. bubble_cnt +1 if out_valid was 1 before the flush.
  3. adv & hazard: out_valid←0 (bubble), stall_cnt +1, bubble_cnt +1.
  4. adv & in_valid: load the decoded bundle, out_valid←1.
  5. adv & !in_valid: out_valid←0; the bundle fields may keep their last values.
  6. !adv: hold everything.
- Latency: 1 cycle from input transfer to out_valid. Full throughput of 1 per cycle when out_ready=1 and there is no hazard.
- A hazard lasts exactly one cycle at out_ready=1, because the load leaves the register. If out_ready=0 while a hazard exists, the stage holds, and stall_cnt still increments each cycle that hazard=1.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Simultaneous flush and hazard: flush wins; stall_cnt does not increment.
- rst asserted mid-transfer: the instruction is lost and no output is produced.

Decomposition:
- Shared defines/package:
  - opcode constants (R, I_ARITH, LOAD, S, B, LUI, AUIPC, JAL, JALR)
  - ALUOp encodings
  - FUNCT3_BLTU/BGEU
  - FUNCT7_MULDIV
  - a control-bundle width constant
- One sub-module, ctrl_decode_comb: the pure combinational table producing controls plus uses_rs1/uses_rs2.
- The top level holds the handshake, the hazard logic, the register and the counters.

Test Plan:
- Reset, then send a single LOAD 0x00012083 with out_ready=1 → next cycle: out_valid=1, reg_wen=1, alu_src=1, mem_to_reg=1, alu_op=01, rd=1.
- LOAD rd=x1 followed by ADD x3,x1,x2 (0x002081B3) → in_ready=0 for one cycle, one bubble (out_valid=0), stall_cnt=1, bubble_cnt=1; the ADD emerges the next cycle with alu_op=00.
- BGEU (funct3=111) with out_ready held 0 for 3 cycles → bundle held stable, in_ready=0, branch=1, br_un=1, alu_op=11; releases on out_ready=1.
- MUL 0x021080B3 with ENABLE_M=1 → md_op=1, reg_wen=1. Same word with ENABLE_M=0 → illegal=1, reg_wen=0. Opcode 0x7F → illegal=1, alu_op=00.
- flush asserted while out_valid=1 and a new instr is presented → out_valid=0 next cycle, instr dropped, bubble_cnt +1. flush together with a hazard → stall_cnt unchanged.
- CNT_W=2, force 5 consecutive hazards → stall_cnt saturates at 3. rst mid-stream → all outputs and counters 0 on the next edge.

Source files
------------

// File: rtl/pipelined_ctrl_decoder_pkg.sv
// Shared decode constants and the control bundle carried from decode to execute.
package pipelined_ctrl_decoder_pkg;

    localparam logic [6:0] OPC_R       = 7'b0110011;
    localparam logic [6:0] OPC_I_ARITH = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_S       = 7'b0100011;
    localparam logic [6:0] OPC_B       = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;

    localparam logic [1:0] ALUOP_R    = 2'b00;
    localparam logic [1:0] ALUOP_I    = 2'b10;
    localparam logic [1:0] ALUOP_ADDR = 2'b01;
    localparam logic [1:0] ALUOP_BR   = 2'b11;

    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic       reg_wen;
        logic       alu_src;
        logic       mem_rw;
        logic       mem_to_reg;
        logic       branch;
        logic       br_un;
        logic       jump;
        logic [1:0] alu_op;
        logic       md_op;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pipelined_ctrl_decoder_ctrl_decode_comb.sv
// Purpose: opcode/funct3/funct7 to control bundle plus source-register usage.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module ctrl_decode_comb
    import pipelined_ctrl_decoder_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    always_comb begin
        ctrl     = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_R: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                if (funct7 == FUNCT7_MULDIV && ENABLE_M == 0) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    ctrl.reg_wen = 1'b1;
                    ctrl.alu_op  = ALUOP_R;
                    ctrl.md_op   = (funct7 == FUNCT7_MULDIV);
                end
            end
            OPC_I_ARITH: begin
                uses_rs1     = 1'b1;
                ctrl.reg_wen = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALUOP_I;
            end
            OPC_LOAD: begin
                uses_rs1        = 1'b1;
                ctrl.reg_wen    = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_op     = ALUOP_ADDR;
            end
            OPC_S: begin
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.mem_rw  = 1'b1;
                ctrl.alu_op  = ALUOP_ADDR;
            end
            OPC_B: begin
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_BR;
                ctrl.br_un  = (funct3 == FUNCT3_BLTU) || (funct3 == FUNCT3_BGEU);
            end
            OPC_LUI, OPC_AUIPC: begin
                ctrl.reg_wen = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALUOP_ADDR;
            end
            OPC_JAL, OPC_JALR: begin
                uses_rs1     = (opcode == OPC_JALR);
                ctrl.reg_wen = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.jump    = 1'b1;
                ctrl.alu_op  = ALUOP_ADDR;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_ctrl_decoder.sv
// Purpose: ID/EX control register with load-use bubble, flush and stall/bubble counters.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready drops when execute stalls the register or a load-use hazard is seen.
module pipelined_ctrl_decoder
    import pipelined_ctrl_decoder_pkg::*;
#(
    parameter int ENABLE_M           = 1,
    parameter int LOAD_USE_INTERLOCK = 1,
    parameter int CNT_W              = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             reg_wen,
    output logic             alu_src,
    output logic             mem_rw,
    output logic             mem_to_reg,
    output logic             branch,
    output logic             br_un,
    output logic             jump,
    output logic [1:0]       alu_op,
    output logic             md_op,
    output logic             illegal,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctrl_t             dec;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              out_valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    ctrl_t             ctrl_r;
    logic [4:0]        rd_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic              raw_hazard;
    logic              hazard;
    logic              adv;

    ctrl_decode_comb #(.ENABLE_M(ENABLE_M)) u_decode (
        .opcode   (instr[6:0]),
        .funct3   (instr[14:12]),
        .funct7   (instr[31:25]),
        .ctrl     (dec),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    assign ctrl_r = ctrl_q;

    // Compare against the load still sitting in the ID/EX register.
    assign raw_hazard = out_valid_q && in_valid && ctrl_r.mem_to_reg && (rd_q != 5'd0) &&
                        ((uses_rs1 && instr[19:15] == rd_q) || (uses_rs2 && instr[24:20] == rd_q));
    assign hazard     = (LOAD_USE_INTERLOCK != 0) && raw_hazard;
    assign adv        = !out_valid_q || out_ready;
    assign in_ready   = adv && !hazard && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            ctrl_q       <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            if (out_valid_q && bubble_cnt_q != '1)
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end else begin
            // A held hazard (out_ready low) still counts as a stall cycle.
            if (hazard && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (adv) begin
                if (hazard) begin
                    out_valid_q <= 1'b0;
                    if (bubble_cnt_q != '1)
                        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
                end else if (in_valid) begin
                    out_valid_q <= 1'b1;
                    ctrl_q      <= dec;
                    rd_q        <= instr[11:7];
                    rs1_q       <= instr[19:15];
                    rs2_q       <= instr[24:20];
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign reg_wen    = ctrl_r.reg_wen;
    assign alu_src    = ctrl_r.alu_src;
    assign mem_rw     = ctrl_r.mem_rw;
    assign mem_to_reg = ctrl_r.mem_to_reg;
    assign branch     = ctrl_r.branch;
    assign br_un      = ctrl_r.br_un;
    assign jump       = ctrl_r.jump;
    assign alu_op     = ctrl_r.alu_op;
    assign md_op      = ctrl_r.md_op;
    assign illegal    = ctrl_r.illegal;
    assign rd         = rd_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipelined_ctrl_decoder.sv
// Two instances (M enabled/16-bit counters, M disabled/2-bit counters) share one stimulus stream.
module tb_pipelined_ctrl_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic        flush;
    logic        out_ready;

    always #5 clk = ~clk;

    logic a_in_ready, a_out_valid, a_reg_wen, a_alu_src, a_mem_rw, a_mem_to_reg;
    logic a_branch, a_br_un, a_jump, a_md_op, a_illegal;
    logic [1:0] a_alu_op;
    logic [4:0] a_rd, a_rs1, a_rs2;
    logic [15:0] a_stall_cnt, a_bubble_cnt;

    logic b_in_ready, b_out_valid, b_reg_wen, b_alu_src, b_mem_rw, b_mem_to_reg;
    logic b_branch, b_br_un, b_jump, b_md_op, b_illegal;
    logic [1:0] b_alu_op;
    logic [4:0] b_rd, b_rs1, b_rs2;
    logic [1:0] b_stall_cnt, b_bubble_cnt;

    pipelined_ctrl_decoder u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .instr(instr),
        .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .reg_wen(a_reg_wen), .alu_src(a_alu_src), .mem_rw(a_mem_rw), .mem_to_reg(a_mem_to_reg),
        .branch(a_branch), .br_un(a_br_un), .jump(a_jump), .alu_op(a_alu_op), .md_op(a_md_op),
        .illegal(a_illegal), .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2),
        .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
    );

    pipelined_ctrl_decoder #(.ENABLE_M(0), .LOAD_USE_INTERLOCK(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .instr(instr),
        .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .reg_wen(b_reg_wen), .alu_src(b_alu_src), .mem_rw(b_mem_rw), .mem_to_reg(b_mem_to_reg),
        .branch(b_branch), .br_un(b_br_un), .jump(b_jump), .alu_op(b_alu_op), .md_op(b_md_op),
        .illegal(b_illegal), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2),
        .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
    );

    logic [25:0] a_bund, b_bund;
    assign a_bund = {a_reg_wen, a_alu_src, a_mem_rw, a_mem_to_reg, a_branch, a_br_un, a_jump,
                     a_alu_op, a_md_op, a_illegal, a_rd, a_rs1, a_rs2};
    assign b_bund = {b_reg_wen, b_alu_src, b_mem_rw, b_mem_to_reg, b_branch, b_br_un, b_jump,
                     b_alu_op, b_md_op, b_illegal, b_rd, b_rs1, b_rs2};

    localparam logic [31:0] W_LOAD = 32'h00012083;   // lw x1, 0(x2)
    localparam logic [31:0] W_ADD  = 32'h002081B3;   // add x3, x1, x2
    localparam logic [31:0] W_BGEU = 32'h0020F063;   // bgeu x1, x2
    localparam logic [31:0] W_ADDI = 32'h00100293;   // addi x5, x0, 1
    localparam logic [31:0] W_SUB  = 32'h40208233;   // sub x4, x1, x2
    localparam logic [31:0] W_MUL  = 32'h021080B3;   // mul x1, x1, x1
    localparam logic [31:0] W_ILL  = 32'h0000007F;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the ID/EX register should hold, and true event counts.
    bit          m_v    = 1'b0;
    bit          m_zero = 1'b1;
    logic [31:0] m_word = '0;
    int          m_stall = 0;
    int          m_bub   = 0;

    function automatic logic [25:0] ref_bundle(input logic [31:0] w, input bit en_m);
        logic rw, as, mrw, m2r, br, bu, jmp, md, ill;
        logic [1:0] aop;
        {rw, as, mrw, m2r, br, bu, jmp, md, ill} = '0;
        aop = 2'b00;
        case (w[6:0])
            7'h33: if (w[31:25] == 7'd1 && !en_m) ill = 1'b1;
                   else begin rw = 1'b1; md = (w[31:25] == 7'd1); end
            7'h13: begin rw = 1'b1; as = 1'b1; aop = 2'b10; end
            7'h03: begin rw = 1'b1; as = 1'b1; m2r = 1'b1; aop = 2'b01; end
            7'h23: begin as = 1'b1; mrw = 1'b1; aop = 2'b01; end
            7'h63: begin br = 1'b1; aop = 2'b11; bu = (w[14:12] >= 3'd6); end
            7'h37, 7'h17: begin rw = 1'b1; as = 1'b1; aop = 2'b01; end
            7'h6F, 7'h67: begin rw = 1'b1; as = 1'b1; jmp = 1'b1; aop = 2'b01; end
            default: ill = 1'b1;
        endcase
        return {rw, as, mrw, m2r, br, bu, jmp, aop, md, ill, w[11:7], w[19:15], w[24:20]};
    endfunction

    function automatic bit reads_rs1(input logic [31:0] w);
        return w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic bit reads_rs2(input logic [31:0] w);
        return w[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic bit ref_hazard(input bit iv, input logic [31:0] w);
        logic [4:0] ld_rd;
        ld_rd = m_word[11:7];
        return m_v && iv && (m_word[6:0] == 7'h03) && (ld_rd != 5'd0) &&
               ((reads_rs1(w) && w[19:15] == ld_rd) || (reads_rs2(w) && w[24:20] == ld_rd));
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid_a", 32'(a_out_valid), 32'(m_v));
        chk("out_valid_b", 32'(b_out_valid), 32'(m_v));
        if (m_v) begin
            chk("bundle_a", 32'(a_bund), 32'(ref_bundle(m_word, 1'b1)));
            chk("bundle_b", 32'(b_bund), 32'(ref_bundle(m_word, 1'b0)));
        end else if (m_zero) begin
            chk("bundle_rst_a", 32'(a_bund), 32'd0);
            chk("bundle_rst_b", 32'(b_bund), 32'd0);
        end
        chk("stall_a",  32'(a_stall_cnt),  32'(sat(m_stall, 65535)));
        chk("stall_b",  32'(b_stall_cnt),  32'(sat(m_stall, 3)));
        chk("bubble_a", 32'(a_bubble_cnt), 32'(sat(m_bub, 65535)));
        chk("bubble_b", 32'(b_bubble_cnt), 32'(sat(m_bub, 3)));
    endtask

    // One clock: drive, check in_ready, advance the model at the edge, check outputs.
    task automatic step(input bit iv, input logic [31:0] w, input bit ordy, input bit fl, input bit r);
        bit haz, adv;
        in_valid  = iv;
        instr     = w;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        haz = ref_hazard(iv, w);
        adv = !m_v || ordy;
        chk("in_ready_a", 32'(a_in_ready), 32'(adv && !haz && !r));
        chk("in_ready_b", 32'(b_in_ready), 32'(adv && !haz && !r));
        @(posedge clk);
        if (r) begin
            m_v = 0; m_zero = 1; m_stall = 0; m_bub = 0;
        end else if (fl) begin
            if (m_v) m_bub++;
            m_v = 0;
        end else begin
            if (haz) m_stall++;
            if (adv && haz) begin
                m_v = 0; m_bub++;
            end else if (adv && iv) begin
                m_v = 1; m_zero = 0; m_word = w;
            end else if (adv) begin
                m_v = 0;
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        logic [6:0]  ops [9];
        logic [6:0]  f7s [3];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h37, 7'h67, 7'h7F};
        f7s = '{7'h00, 7'h20, 7'h01};
        {rst, in_valid, flush, out_ready} = 4'b1000;
        instr = '0;

        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);

        // Single load, then its decoded bundle checked against literal values.
        step(1, W_LOAD, 1, 0, 0);
        chk("load_literal", 32'(a_bund),
            32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0}));
        step(0, 0, 1, 0, 0);

        // Load-use: ADD depends on x1 just loaded.
        step(1, W_LOAD, 1, 0, 0);
        step(1, W_ADD, 1, 0, 0);
        chk("lu_stall_literal", 32'(a_stall_cnt), 32'd1);
        step(1, W_ADD, 1, 0, 0);
        chk("add_aluop", 32'(a_alu_op), 32'd0);
        step(0, 0, 1, 0, 0);

        // BGEU held under backpressure.
        step(1, W_BGEU, 1, 0, 0);
        repeat (3) step(1, W_ADDI, 0, 0, 0);
        chk("bgeu_literal", 32'({a_branch, a_br_un, a_alu_op}), 32'b1111);
        step(1, W_ADDI, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // M extension on/off and an unknown opcode.
        step(1, W_MUL, 1, 0, 0);
        chk("mul_a_literal", 32'({a_md_op, a_reg_wen, a_illegal}), 32'b110);
        chk("mul_b_literal", 32'({b_md_op, b_reg_wen, b_illegal}), 32'b001);
        step(1, W_ILL, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Flush with a valid bundle, then flush coinciding with a hazard.
        step(1, W_ADDI, 1, 0, 0);
        step(1, W_SUB, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(1, W_LOAD, 1, 0, 0);
        step(1, W_ADD, 1, 1, 0);
        step(0, 0, 1, 0, 0);

        // Sustained hazard under backpressure saturates the narrow counter.
        step(1, W_LOAD, 1, 0, 0);
        repeat (5) step(1, W_ADD, 0, 0, 0);
        chk("stall_sat_literal", 32'(b_stall_cnt), 32'd3);
        step(1, W_ADD, 1, 0, 0);
        step(1, W_ADD, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Reset in the middle of traffic.
        step(1, W_ADDI, 1, 0, 0);
        step(1, W_LOAD, 1, 0, 1);
        step(0, 0, 1, 0, 0);

        // Randomised traffic over a small register range to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            w = {f7s[$urandom_range(2)], 3'b000, 2'($urandom_range(3)), 3'b000, 2'($urandom_range(3)),
                 3'($urandom), 3'b000, 2'($urandom_range(3)), ops[$urandom_range(8)]};
            step(($urandom % 4) != 0, w, ($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 80) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
